freq_period_meter: RTL and testbench

// - Period/frequency meter for a pre-synchronised square wave (comparator output), 1 kHz-100 kHz at 200 MHz clk.
// - Successor to the fixed 4-deep detector: parametric history depth, running-sum average, tolerance against
//   the average, high-time (duty) capture, no-signal timeout, update strobe.
// - Sits between the comparator synchroniser and the frequency/display logic.

---
 rtl/freq_meter_pkg.sv | 17 +
 rtl/freq_edge_timer.sv | 71 +++++++
 rtl/freq_period_meter.sv | 152 +++++++++++++++
 tb/tb_freq_period_meter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the period/frequency meter.
// Defaults assume a 200 MHz system clock and inputs of 1 kHz or faster.
package freq_meter_pkg;
    localparam int DEF_CNT_W = 18;
    localparam int CLK_HZ    = 200_000_000;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        TRACK,
        LOCKED
    } meter_state_t;

    function automatic bit depth_ok(input int d);
        return (d >= 2) && (d <= 16) && ((d & (d - 1)) == 0);
    endfunction
endpackage

// File: rtl/freq_edge_timer.sv
// Edge detect, period/high-time counters, arming and no-signal timeout.
// Captured values and strobes appear one cycle after the rising edge.
module freq_edge_timer
    import freq_meter_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = (1 << CNT_W) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sig,
    output logic             o_arm,
    output logic             o_cap,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_timeout
);
    localparam logic [CNT_W-1:0] LIM  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LIM1 = CNT_W'(TIMEOUT - 1);

    logic             r_prev;
    logic             r_armed;
    logic             r_fell;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi;
    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_inc;

    assign w_rise    = ~r_prev & i_sig;
    assign w_fall    = r_prev & ~i_sig;
    assign w_inc     = r_cnt + 1'b1;
    // A rise on the boundary cycle beats the timeout.
    assign o_timeout = ~w_rise & (r_cnt == LIM1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev   <= 1'b0;
            r_armed  <= 1'b0;
            r_fell   <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            o_arm    <= 1'b0;
            o_cap    <= 1'b0;
            o_period <= '0;
            o_high   <= '0;
        end else begin
            r_prev <= i_sig;
            o_arm  <= 1'b0;
            o_cap  <= 1'b0;
            if (w_rise) begin
                r_cnt   <= '0;
                r_fell  <= 1'b0;
                r_armed <= 1'b1;
                o_arm   <= ~r_armed;
                o_cap   <= r_armed;
                if (r_armed) begin
                    o_period <= w_inc;
                    o_high   <= r_fell ? r_hi : w_inc;
                end
            end else begin
                if (r_cnt != LIM) r_cnt <= w_inc;
                if (w_fall) begin
                    r_hi   <= w_inc;
                    r_fell <= 1'b1;
                end
                if (o_timeout) r_armed <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/freq_period_meter.sv
// Averaging period meter: history ring, running sum, tolerance FSM.
// Results and strobe appear two cycles after each armed rising edge.
module freq_period_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int DEPTH         = 8,
    parameter int THRESH_SHIFT  = 5,
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = (1 << CNT_W) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             signal_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             stable,
    output logic             no_signal
);
    localparam int LOG2D = $clog2(DEPTH);
    localparam int SUM_W = CNT_W + LOG2D;
    localparam int SC_W  = $clog2(STABLE_CYCLES + 1);
    localparam logic [LOG2D:0]  FULL   = (LOG2D + 1)'(DEPTH);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CYCLES);

    if (!depth_ok(DEPTH) || THRESH_SHIFT >= CNT_W) begin : g_bad_cfg
        $error("freq_period_meter: bad DEPTH or THRESH_SHIFT");
    end

    logic             w_arm;
    logic             w_cap;
    logic             w_to;
    logic [CNT_W-1:0] w_new;
    logic [CNT_W-1:0] w_hi;

    freq_edge_timer #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sig    (signal_in),
        .o_arm    (w_arm),
        .o_cap    (w_cap),
        .o_period (w_new),
        .o_high   (w_hi),
        .o_timeout(w_to)
    );

    logic [CNT_W-1:0] r_hist [DEPTH];
    logic [LOG2D-1:0] r_wr;
    logic [LOG2D:0]   r_fill;
    logic [LOG2D:0]   w_fill_nx;
    logic [SUM_W-1:0] r_sum;
    logic [SUM_W-1:0] w_sum_nx;
    logic [CNT_W-1:0] w_avg;
    logic [CNT_W-1:0] w_tol;
    logic [CNT_W:0]   w_new_x;
    logic [CNT_W:0]   w_avg_x;
    logic [CNT_W:0]   w_tol_x;
    logic             w_in_tol;
    logic [SC_W-1:0]  r_scnt;
    meter_state_t     r_state;
    meter_state_t     w_state_nx;

    // Unfilled slots hold zero, so the sum is exact while filling.
    assign w_sum_nx  = r_sum + SUM_W'(w_new) - SUM_W'(r_hist[r_wr]);
    assign w_fill_nx = (r_fill == FULL) ? r_fill : r_fill + 1'b1;
    assign w_avg     = CNT_W'(r_sum >> LOG2D);
    assign w_tol     = w_avg >> THRESH_SHIFT;
    assign w_new_x   = {1'b0, w_new};
    assign w_avg_x   = {1'b0, w_avg};
    assign w_tol_x   = {1'b0, w_tol};
    assign w_in_tol  = (w_new_x <= w_avg_x + w_tol_x) &&
                       (w_new_x + w_tol_x >= w_avg_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
            r_wr         <= '0;
            r_fill       <= '0;
            r_sum        <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            no_signal    <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (w_to) begin
                for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
                r_wr      <= '0;
                r_fill    <= '0;
                r_sum     <= '0;
                no_signal <= 1'b1;
            end else begin
                if (w_arm) no_signal <= 1'b0;
                if (w_cap) begin
                    r_hist[r_wr] <= w_new;
                    r_wr         <= r_wr + 1'b1;
                    r_sum        <= w_sum_nx;
                    r_fill       <= w_fill_nx;
                    period       <= (w_fill_nx == FULL) ?
                                    CNT_W'(w_sum_nx >> LOG2D) : w_new;
                    high_time    <= w_hi;
                    period_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scnt <= '0;
        end else if (w_to || r_state == IDLE || r_state == FILL) begin
            r_scnt <= '0;
        end else if (w_cap) begin
            if (!w_in_tol) r_scnt <= '0;
            else if (r_scnt != SC_MAX) r_scnt <= r_scnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_to) begin
            w_state_nx = IDLE;
        end else begin
            unique case (r_state)
                IDLE:
                    if (w_arm) w_state_nx = FILL;
                FILL:
                    if (w_cap && w_fill_nx == FULL) w_state_nx = TRACK;
                TRACK:
                    if (w_cap && w_in_tol && (r_scnt + 1'b1 == SC_MAX))
                        w_state_nx = LOCKED;
                LOCKED:
                    if (w_cap && !w_in_tol) w_state_nx = TRACK;
                default:
                    w_state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        stable = (r_state == LOCKED);
    end
endmodule

// File: tb/tb_freq_period_meter.sv
// Directed bench for freq_period_meter, scaled to a 12-bit counter
// (timeout 4095) so every scenario fits in a short run.
module tb_freq_period_meter;
    localparam int CW = 12;
    localparam int TO = 4095;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          sig   = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          period_valid;
    logic          stable;
    logic          no_signal;

    int cyc       = 0;
    int n_chk     = 0;
    int n_pass    = 0;
    int strobes   = 0;
    int last_sc   = 0;
    int gap       = 0;
    int last_rise = 0;
    int n_ref     = 0;

    freq_period_meter #(
        .CNT_W        (CW),
        .DEPTH        (8),
        .THRESH_SHIFT (5),
        .STABLE_CYCLES(4),
        .TIMEOUT      (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .signal_in   (sig),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .stable      (stable),
        .no_signal   (no_signal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && period_valid) begin
            gap     = cyc - last_sc;
            last_sc = cyc;
            strobes++;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One period starting with a rising edge; p clocks total, h high.
    task automatic pulse(input int p, input int h);
        sig       = 1'b1;
        last_rise = cyc + 1;
        repeat (h) @(negedge clk);
        sig = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_period", int'(period), 0);
        chk("rst_high", int'(high_time), 0);
        chk("rst_valid", int'(period_valid), 0);
        chk("rst_stable", int'(stable), 0);
        chk("rst_nosig", int'(no_signal), 0);
        rst_n = 1'b1;
        @(negedge clk);

        repeat (12) pulse(200, 100);
        chk("stable_pre", int'(stable), 0);
        pulse(200, 100);
        chk("stable_lock", int'(stable), 1);
        chk("n_strobe", strobes, 12);
        chk("strobe_gap", gap, 200);
        chk("lock_period", int'(period), 200);
        chk("lock_high", int'(high_time), 100);

        pulse(210, 105);
        pulse(200, 100);
        chk("drop_stable", int'(stable), 0);
        chk("drop_period", int'(period), 201);
        chk("drop_high", int'(high_time), 105);
        repeat (4) pulse(200, 100);
        chk("relock", int'(stable), 1);
        pulse(204, 102);
        pulse(200, 100);
        chk("small_stable", int'(stable), 1);
        chk("small_period", int'(period), 201);

        n_ref = strobes;
        sig   = 1'b0;
        for (int i = 0; i < 5000 && !no_signal; i++) @(negedge clk);
        chk("to_delay", cyc - last_rise, TO);
        chk("to_nosig", int'(no_signal), 1);
        chk("to_stable", int'(stable), 0);
        chk("to_period", int'(period), 201);
        chk("to_strobes", strobes, n_ref);

        pulse(200, 100);
        chk("rearm_nostrobe", strobes, n_ref);
        chk("rearm_nosig", int'(no_signal), 0);
        pulse(200, 100);
        chk("rearm_strobe", strobes, n_ref + 1);
        chk("rearm_period", int'(period), 200);
        chk("rearm_high", int'(high_time), 100);

        pulse(TO, 100);
        chk("edge_nosig_a", int'(no_signal), 0);
        pulse(200, 100);
        chk("edge_period", int'(period), TO);
        chk("edge_nosig_b", int'(no_signal), 0);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        repeat (13) pulse(200, 100);
        chk("relock2", int'(stable), 1);
        sig = 1'b1;
        repeat (50) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid", int'({period, high_time, period_valid,
                                 stable, no_signal}), 0);
        sig = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_ref = strobes;
        pulse(200, 100);
        chk("post_rst_arm", strobes, n_ref);
        pulse(200, 100);
        chk("post_rst_cap", strobes, n_ref + 1);
        chk("post_rst_period", int'(period), 200);

        repeat (10) pulse(20, 10);
        chk("fast_period", int'(period), 20);
        repeat (8) pulse(2000, 1000);
        chk("step_partial", int'(period), 1752);
        pulse(2000, 1000);
        chk("step_final", int'(period), 2000);
        chk("step_high", int'(high_time), 1000);
        chk("step_nosig", int'(no_signal), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
